// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store-lane helpers for the load/store sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Everything about the access captured when it leaves IDLE.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    // Loads only define 000/001/010/100/101; stores only 000/001/010.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_SW);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
        if (!we)
            return BE_WORD;
        case (f3[1:0])
            2'b00:   return BE_BYTE << off;
            2'b01:   return BE_HALF << {off[1], 1'b0};
            default: return BE_WORD;
        endcase
    endfunction

    // Replicate the store value across every lane so the BE alone picks the bytes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a raw DMEM word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select then extension chosen by load type.
    always_comb begin
        lane_b   = raw_word[7:0];
        lane_h   = offset[1] ? raw_word[31:16] : raw_word[15:0];
        ext_data = raw_word;
        case (offset)
            2'b00:   lane_b = raw_word[7:0];
            2'b01:   lane_b = raw_word[15:8];
            2'b10:   lane_b = raw_word[23:16];
            default: lane_b = raw_word[31:24];
        endcase
        case (funct3)
            F3_LB:   ext_data = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  ext_data = {24'd0, lane_b};
            F3_LH:   ext_data = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  ext_data = {16'd0, lane_h};
            default: ext_data = raw_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequences one load/store per instruction onto a req/gnt/rvalid DMEM port.
// Latency: store 2 cycles min (REQ, DONE); load 3 min (REQ, WAIT, DONE).
// Backpressure: req held until gnt, PC stalled through REQ/WAIT; load faults after TIMEOUT WAIT cycles.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misalign,
    output logic              o_fault,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state_q, state_d;
    lsu_req_t          req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic [31:0]       rdata_q;
    logic [31:0]       ext_data;
    logic              req_illegal;
    logic              req_misalign;
    logic              req_ok;
    logic              wait_expired;
    logic              in_req;

    assign req_illegal  = f3_illegal(i_wren, i_funct3);
    assign req_misalign = !req_illegal && f3_misaligned(i_funct3, i_addr[1:0]);
    assign req_ok       = i_req && !req_illegal && !req_misalign;
    assign wait_expired = (state_q == ST_WAIT) && !i_mem_rvalid && (cnt_q == CNT_LAST);
    assign in_req       = (state_q == ST_REQ);

    lsu_load_align u_load_align (
        .raw_word (i_mem_rdata),
        .offset   (req_q.addr[1:0]),
        .funct3   (req_q.funct3),
        .ext_data (ext_data)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and handshake/status outputs; rejected requests answer in IDLE without a DMEM access.
    always_comb begin
        state_d    = state_q;
        o_stall    = 1'b0;
        o_done     = 1'b0;
        o_misalign = 1'b0;
        o_fault    = 1'b0;
        o_mem_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    if (req_illegal) begin
                        o_fault = 1'b1;
                        o_done  = 1'b1;
                    end else if (req_misalign) begin
                        o_misalign = 1'b1;
                        o_done     = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                o_stall   = 1'b1;
                o_mem_req = 1'b1;
                if (i_mem_gnt)
                    state_d = req_q.we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_mem_rvalid || (cnt_q == CNT_LAST))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                o_fault = fault_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the accepted access, with BE and lane data precomputed for the REQ cycle(s).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            req_q <= '0;
        else if ((state_q == ST_IDLE) && req_ok)
            req_q <= '{addr:   i_addr,
                       funct3: i_funct3,
                       we:     i_wren,
                       be:     store_be(i_wren, i_funct3, i_addr[1:0]),
                       wdata:  i_wren ? store_data(i_funct3, i_wdata) : 32'd0};
    end

    // WAIT cycle counter, cleared while the request is outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else if (state_q == ST_REQ)
            cnt_q <= '0;
        else if (state_q == ST_WAIT)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    // Remember a timeout so the fault pulse lines up with the DONE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            fault_q <= 1'b0;
        else
            fault_q <= wait_expired;
    end

    // Load result: updated only by a completing or timed-out load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rdata_q <= '0;
        else if ((state_q == ST_WAIT) && i_mem_rvalid)
            rdata_q <= ext_data;
        else if (wait_expired)
            rdata_q <= '0;
    end

    assign o_rdata     = rdata_q;
    assign o_mem_we    = in_req & req_q.we;
    assign o_mem_addr  = in_req ? {req_q.addr[ADDR_W-1:2], 2'b00} : '0;
    assign o_mem_be    = in_req ? req_q.be : 4'd0;
    assign o_mem_wdata = in_req ? req_q.wdata : 32'd0;

endmodule
